// File: rtl/var_cell_if.sv
// Interface bundling the variable cell's column-side and controller-side
// signals. Directions are named from the cell's point of view: the cell
// uses the slave modport, the controller/bench uses the master modport.
interface var_cell_if #(
  parameter int NUM_CLAUSES = 8,
  parameter int LEVEL_W     = 8,
  parameter int IDX_W       = 3
);
  // Column traffic to/from the lit cells
  logic [3*NUM_CLAUSES-1:0] var_value_i;
  logic [2:0]               var_value_o;
  logic                     cmark_o;

  // Decision / implication / backtrack controls
  logic                     decide_i;
  logic [1:0]               decide_val_i;
  logic [LEVEL_W-1:0]       cur_level_i;
  logic                     imp_en_i;
  logic                     bt_i;
  logic [LEVEL_W-1:0]       bt_level_i;

  // State load path (bin swap-in)
  logic                     wr_i;
  logic [2:0]               wr_value_i;
  logic [LEVEL_W-1:0]       wr_level_i;

  // Status back to the controller
  logic [LEVEL_W-1:0]       level_o;
  logic [IDX_W-1:0]         reason_o;
  logic                     implied_o;
  logic                     conflict_o;

  modport slave (
    input  var_value_i, decide_i, decide_val_i, cur_level_i, imp_en_i,
           bt_i, bt_level_i, wr_i, wr_value_i, wr_level_i,
    output var_value_o, cmark_o, level_o, reason_o, implied_o, conflict_o
  );

  modport master (
    output var_value_i, decide_i, decide_val_i, cur_level_i, imp_en_i,
           bt_i, bt_level_i, wr_i, wr_value_i, wr_level_i,
    input  var_value_o, cmark_o, level_o, reason_o, implied_o, conflict_o
  );
endinterface

// File: rtl/var_cell.sv
// Variable cell of a SAT-solver column. Holds one variable's assignment
// (free / decided / implied / conflict), the level at which it was assigned
// and the clause that caused an implication or conflict. Lit cells in the
// column drive suggested values; the cell arbitrates them against decisions,
// backtracks and state loads.
module var_cell #(
  parameter int NUM_CLAUSES = 8,
  parameter int LEVEL_W     = 8,
  parameter int IDX_W       = 3
) (
  input logic       clk,
  input logic       rst,
  var_cell_if.slave bus
);

  typedef enum logic [1:0] {
    ST_FREE     = 2'd0,
    ST_DECIDED  = 2'd1,
    ST_IMPLIED  = 2'd2,
    ST_CONFLICT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         val_q, val_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [IDX_W-1:0]   reason_q, reason_d;
  logic               implied_q, implied_d;

  // Per-slice decode of the lit-cell suggestions
  logic [NUM_CLAUSES-1:0] drv10;
  logic [NUM_CLAUSES-1:0] drv01;
  logic [NUM_CLAUSES-1:0] mark11;
  logic [NUM_CLAUSES-1:0] unused_slice_implied;

  generate
    for (genvar gi = 0; gi < NUM_CLAUSES; gi++) begin : g_slice
      assign drv10[gi]  = (bus.var_value_i[3*gi+2 -: 2] == 2'b10);
      assign drv01[gi]  = (bus.var_value_i[3*gi+2 -: 2] == 2'b01);
      assign mark11[gi] = (bus.var_value_i[3*gi+2 -: 2] == 2'b11);
      // The lit cells' implied flag carries no meaning for arbitration here
      assign unused_slice_implied[gi] = bus.var_value_i[3*gi];
    end
  endgenerate

  logic             any10, any01;
  logic [IDX_W-1:0] first10, first01;

  assign any10 = |drv10;
  assign any01 = |drv01;

  // Lowest-index drivers of each polarity (scan high to low so the lowest wins)
  always_comb begin
    first10 = '0;
    first01 = '0;
    for (int k = NUM_CLAUSES - 1; k >= 0; k--) begin
      if (drv10[k]) first10 = IDX_W'(k);
      if (drv01[k]) first01 = IDX_W'(k);
    end
  end

  logic decide_legal;
  assign decide_legal = (bus.decide_val_i == 2'b10) || (bus.decide_val_i == 2'b01);

  // Next-state arbitration: load > backtrack > implication > decision
  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    level_d   = level_q;
    reason_d  = reason_q;
    implied_d = 1'b0;

    if (bus.wr_i) begin
      level_d  = bus.wr_level_i;
      reason_d = '0;
      val_d    = bus.wr_value_i[2:1];
      case (bus.wr_value_i[2:1])
        2'b00:   state_d = ST_FREE;
        2'b11:   state_d = ST_CONFLICT;
        default: state_d = bus.wr_value_i[0] ? ST_IMPLIED : ST_DECIDED;
      endcase
    end else if (bus.bt_i) begin
      // A backtrack strobe owns the cycle even when it leaves the state alone
      if (state_q != ST_FREE && level_q > bus.bt_level_i) begin
        state_d  = ST_FREE;
        val_d    = 2'b00;
        level_d  = '0;
        reason_d = '0;
      end
    end else begin
      case (state_q)
        ST_FREE: begin
          if (bus.imp_en_i && any10 && any01) begin
            // Blame the first clause that contradicts the lowest-index driver
            state_d  = ST_CONFLICT;
            val_d    = 2'b11;
            level_d  = bus.cur_level_i;
            reason_d = (first10 < first01) ? first01 : first10;
          end else if (bus.imp_en_i && (any10 || any01)) begin
            state_d   = ST_IMPLIED;
            val_d     = any10 ? 2'b10 : 2'b01;
            level_d   = bus.cur_level_i;
            reason_d  = any10 ? first10 : first01;
            implied_d = 1'b1;
          end else if (bus.decide_i && decide_legal) begin
            state_d  = ST_DECIDED;
            val_d    = bus.decide_val_i;
            level_d  = bus.cur_level_i;
            reason_d = '0;
          end
        end
        ST_DECIDED, ST_IMPLIED: begin
          // Only drivers of the opposite polarity matter once assigned
          if (bus.imp_en_i) begin
            if (val_q == 2'b10 && any01) begin
              state_d  = ST_CONFLICT;
              val_d    = 2'b11;
              reason_d = first01;
            end else if (val_q == 2'b01 && any10) begin
              state_d  = ST_CONFLICT;
              val_d    = 2'b11;
              reason_d = first10;
            end
          end
        end
        default: ; // CONFLICT holds until a load or backtrack
      endcase
    end
  end

  // State register with synchronous reset overriding every strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FREE;
      val_q     <= 2'b00;
      level_q   <= '0;
      reason_q  <= '0;
      implied_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      level_q   <= level_d;
      reason_q  <= reason_d;
      implied_q <= implied_d;
    end
  end

  // Broadcast value is derived from the state so it is always consistent
  always_comb begin
    case (state_q)
      ST_DECIDED:  bus.var_value_o = {val_q, 1'b0};
      ST_IMPLIED:  bus.var_value_o = {val_q, 1'b1};
      ST_CONFLICT: bus.var_value_o = 3'b110;
      default:     bus.var_value_o = 3'b000;
    endcase
  end

  assign bus.level_o    = level_q;
  assign bus.reason_o   = reason_q;
  assign bus.implied_o  = implied_q;
  assign bus.conflict_o = (state_q == ST_CONFLICT);
  assign bus.cmark_o    = |mark11;

endmodule

// File: tb/tb_var_cell.sv
// Directed bench for var_cell: hand-computed vectors covering reset,
// implication, conflict, decision, backtrack and state load.
module tb_var_cell;
  localparam int NC = 8;
  localparam int LW = 8;
  localparam int IW = 3;

  logic clk;
  logic rst;
  int   total_cnt;
  int   bad_cnt;

  var_cell_if #(.NUM_CLAUSES(NC), .LEVEL_W(LW), .IDX_W(IW)) bus();

  var_cell #(.NUM_CLAUSES(NC), .LEVEL_W(LW), .IDX_W(IW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.var_value_i  = '0;
    bus.decide_i     = 1'b0;
    bus.decide_val_i = 2'b00;
    bus.cur_level_i  = '0;
    bus.imp_en_i     = 1'b0;
    bus.bt_i         = 1'b0;
    bus.bt_level_i   = '0;
    bus.wr_i         = 1'b0;
    bus.wr_value_i   = 3'b000;
    bus.wr_level_i   = '0;
  endtask

  task automatic set_slice(input int k, input logic [2:0] v);
    bus.var_value_i[3*k +: 3] = v;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    total_cnt = 0;
    bad_cnt   = 0;
    idle_inputs();

    // Reset wins over a simultaneous load of an implied value
    rst = 1'b1;
    bus.wr_i       = 1'b1;
    bus.wr_value_i = 3'b011;
    bus.wr_level_i = 8'd7;
    step();
    check_val("rst_value",    32'(bus.var_value_o), 32'h0);
    check_val("rst_level",    32'(bus.level_o),     32'h0);
    check_val("rst_reason",   32'(bus.reason_o),    32'h0);
    check_val("rst_implied",  32'(bus.implied_o),   32'h0);
    check_val("rst_conflict", 32'(bus.conflict_o),  32'h0);

    // Following load takes effect, no implied pulse
    rst = 1'b0;
    step();
    check_val("wr_value",   32'(bus.var_value_o), 32'h3);
    check_val("wr_level",   32'(bus.level_o),     32'h7);
    check_val("wr_implied", 32'(bus.implied_o),   32'h0);
    check_val("wr_reason",  32'(bus.reason_o),    32'h0);

    // Single driver at slice 3 -> implied 10, reason 3, one-cycle pulse
    do_reset();
    bus.imp_en_i    = 1'b1;
    bus.cur_level_i = 8'd5;
    set_slice(3, 3'b100);
    step();
    check_val("imp_value",   32'(bus.var_value_o), 32'h5);
    check_val("imp_level",   32'(bus.level_o),     32'h5);
    check_val("imp_reason",  32'(bus.reason_o),    32'h3);
    check_val("imp_pulse",   32'(bus.implied_o),   32'h1);
    idle_inputs();
    step();
    check_val("imp_pulse_end", 32'(bus.implied_o),   32'h0);
    check_val("imp_hold",      32'(bus.var_value_o), 32'h5);

    // cmark: purely combinational OR of 11 slices, no clock needed
    set_slice(5, 3'b110);
    #1;
    check_val("cmark_set", 32'(bus.cmark_o), 32'h1);
    set_slice(5, 3'b100);
    #1;
    check_val("cmark_clr", 32'(bus.cmark_o), 32'h0);
    idle_inputs();

    // Disagreeing drivers 2=01, 6=10: lowest driver is 01, so blame slice 6
    do_reset();
    bus.imp_en_i    = 1'b1;
    bus.cur_level_i = 8'd2;
    set_slice(2, 3'b011);
    set_slice(6, 3'b101);
    step();
    check_val("cfl_value",    32'(bus.var_value_o), 32'h6);
    check_val("cfl_flag",     32'(bus.conflict_o),  32'h1);
    check_val("cfl_reason",   32'(bus.reason_o),    32'h6);
    check_val("cfl_level",    32'(bus.level_o),     32'h2);
    check_val("cfl_nopulse",  32'(bus.implied_o),   32'h0);
    bus.var_value_i = '0;
    set_slice(0, 3'b100);
    step();
    check_val("cfl_hold_value",  32'(bus.var_value_o), 32'h6);
    check_val("cfl_hold_reason", 32'(bus.reason_o),    32'h6);
    // Backtrack below the conflict level frees it
    idle_inputs();
    bus.bt_i       = 1'b1;
    bus.bt_level_i = 8'd1;
    step();
    check_val("cfl_bt_value", 32'(bus.var_value_o), 32'h0);
    check_val("cfl_bt_flag",  32'(bus.conflict_o),  32'h0);
    check_val("cfl_bt_level", 32'(bus.level_o),     32'h0);

    // Implication beats a simultaneous decision
    do_reset();
    bus.decide_i     = 1'b1;
    bus.decide_val_i = 2'b10;
    bus.imp_en_i     = 1'b1;
    bus.cur_level_i  = 8'd3;
    set_slice(0, 3'b010);
    step();
    check_val("prio_value",  32'(bus.var_value_o), 32'h3);
    check_val("prio_reason", 32'(bus.reason_o),    32'h0);
    check_val("prio_pulse",  32'(bus.implied_o),   32'h1);

    // Agreeing drivers 2 and 5 -> reason is the lowest, 2
    do_reset();
    bus.imp_en_i    = 1'b1;
    bus.cur_level_i = 8'd1;
    set_slice(5, 3'b010);
    set_slice(2, 3'b011);
    step();
    check_val("agree_value",  32'(bus.var_value_o), 32'h3);
    check_val("agree_reason", 32'(bus.reason_o),    32'h2);

    // Decision at level 4, then backtrack boundary checks
    do_reset();
    bus.decide_i     = 1'b1;
    bus.decide_val_i = 2'b10;
    bus.cur_level_i  = 8'd4;
    step();
    check_val("dec_value",   32'(bus.var_value_o), 32'h4);
    check_val("dec_level",   32'(bus.level_o),     32'h4);
    check_val("dec_nopulse", 32'(bus.implied_o),   32'h0);
    // Decide outside FREE is ignored
    bus.decide_val_i = 2'b01;
    step();
    check_val("dec_ignored", 32'(bus.var_value_o), 32'h4);
    idle_inputs();
    bus.bt_i       = 1'b1;
    bus.bt_level_i = 8'd4;
    step();
    check_val("bt_eq_value", 32'(bus.var_value_o), 32'h4);
    check_val("bt_eq_level", 32'(bus.level_o),     32'h4);
    bus.bt_level_i = 8'd3;
    step();
    check_val("bt_lt_value", 32'(bus.var_value_o), 32'h0);
    check_val("bt_lt_level", 32'(bus.level_o),     32'h0);

    // Illegal decide value is ignored
    do_reset();
    bus.decide_i     = 1'b1;
    bus.decide_val_i = 2'b11;
    bus.cur_level_i  = 8'd2;
    step();
    check_val("dec_illegal", 32'(bus.var_value_o), 32'h0);

    // Assigned 01 at level 6; opposite drivers at 4 and 7 -> reason 4, level kept
    do_reset();
    bus.decide_i     = 1'b1;
    bus.decide_val_i = 2'b01;
    bus.cur_level_i  = 8'd6;
    step();
    check_val("dec01_value", 32'(bus.var_value_o), 32'h2);
    idle_inputs();
    bus.imp_en_i    = 1'b1;
    bus.cur_level_i = 8'd9;
    set_slice(1, 3'b010);
    set_slice(4, 3'b100);
    set_slice(7, 3'b101);
    step();
    check_val("asg_cfl_value",  32'(bus.var_value_o), 32'h6);
    check_val("asg_cfl_reason", 32'(bus.reason_o),    32'h4);
    check_val("asg_cfl_level",  32'(bus.level_o),     32'h6);

    // Reset in CONFLICT returns to FREE
    idle_inputs();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_val("rst_cfl_value", 32'(bus.var_value_o), 32'h0);
    check_val("rst_cfl_flag",  32'(bus.conflict_o),  32'h0);

    // Load encodings: 11 -> CONFLICT, 10/0 -> DECIDED, 00 -> FREE
    bus.wr_i       = 1'b1;
    bus.wr_value_i = 3'b110;
    bus.wr_level_i = 8'd3;
    step();
    check_val("wr_cfl_flag", 32'(bus.conflict_o),  32'h1);
    bus.wr_value_i = 3'b100;
    step();
    check_val("wr_dec_value", 32'(bus.var_value_o), 32'h4);
    check_val("wr_dec_flag",  32'(bus.conflict_o),  32'h0);
    bus.wr_value_i = 3'b000;
    step();
    check_val("wr_free_value", 32'(bus.var_value_o), 32'h0);
    idle_inputs();
    step();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
